// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared game-mode encodings, mode masks and tick defaults
package tick_pkg;

  localparam int MODE_W         = 3;
  localparam int NUM_MODES      = 1 << MODE_W;
  localparam int DEFAULT_PERIOD = 16385;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE      = 3'b000,
    MODE_ATTRACT   = 3'b001,
    MODE_PLAY      = 3'b010,
    MODE_PAUSE     = 3'b011,
    MODE_DEATH     = 3'b100,
    MODE_BONUS     = 3'b101,
    MODE_LEVEL_END = 3'b110,
    MODE_GAME_OVER = 3'b111
  } game_mode_e;

  // Per-channel run masks: bit m set means the channel runs in mode m.
  localparam logic [NUM_MODES-1:0] MASK_NONE     = 8'b0000_0000;
  localparam logic [NUM_MODES-1:0] MASK_GAMEPLAY = 8'b0010_0101;
  localparam logic [NUM_MODES-1:0] MASK_PLAY     = 8'b0000_0100;
  localparam logic [NUM_MODES-1:0] MASK_ALL      = 8'b1111_1111;

  // One-hot mask bit for a single mode, handy for building custom masks.
  function automatic logic [NUM_MODES-1:0] mode_bit(input game_mode_e m);
    logic [NUM_MODES-1:0] r;
    r = '0;
    r[m] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one tick channel: period register, phase counter, tick and overrun flags
module tick_channel
  import tick_pkg::*;
#(
  parameter int CNT_W          = 15,
  parameter int DEFAULT_PERIOD = tick_pkg::DEFAULT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active_i,
  input  logic             pulse_mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             period_we_i,
  input  logic             ack_i,
  output logic             tick_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             overrun_q, overrun_d;
  // Set when the tick currently high is a sticky level waiting for an ack.
  logic             sticky_q, sticky_d;
  logic             fire;
  logic             ack_eff;

  // Next-state: period write beats inactivity, which beats normal counting.
  always_comb begin
    period_d  = period_q;
    cnt_d     = cnt_q;
    tick_d    = tick_q;
    overrun_d = overrun_q;
    sticky_d  = sticky_q;
    fire      = 1'b0;
    // An ack only matters for a sticky tick, or when the channel is sticky now.
    ack_eff   = ack_i & (sticky_q | ~pulse_mode_i);

    if (period_we_i) begin
      period_d = period_i;
      cnt_d    = '0;
      tick_d   = 1'b0;
      sticky_d = 1'b0;
    end else if (!active_i) begin
      cnt_d     = '0;
      tick_d    = 1'b0;
      overrun_d = 1'b0;
      sticky_d  = 1'b0;
    end else begin
      if (period_q == '0) begin
        cnt_d = '0;
      end else if (cnt_q == period_q - ONE) begin
        fire  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end

      if (fire) begin
        tick_d   = 1'b1;
        sticky_d = ~pulse_mode_i;
        // A fire coinciding with an ack wins the tick but clears overrun.
        if (ack_eff) begin
          overrun_d = 1'b0;
        end else if (!pulse_mode_i && tick_q && sticky_q) begin
          overrun_d = 1'b1;
        end
      end else if (ack_eff) begin
        tick_d    = 1'b0;
        overrun_d = 1'b0;
        sticky_d  = 1'b0;
      end else if (!sticky_q) begin
        tick_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset to the default period.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q  <= RST_PERIOD;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      overrun_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      overrun_q <= overrun_d;
      sticky_q  <= sticky_d;
    end
  end

  assign tick_o    = tick_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/tick_generator_mc.sv
// rtl/tick_generator_mc.sv - multi-channel mode-gated tick generator
module tick_generator_mc #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 15,
  parameter int MODE_W         = tick_pkg::MODE_W,
  parameter int DEFAULT_PERIOD = tick_pkg::DEFAULT_PERIOD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MODE_W-1:0]             mode,
  input  logic [NUM_CH*(2**MODE_W)-1:0] mode_mask,
  input  logic [NUM_CH-1:0]             pulse_mode,
  input  logic [CNT_W-1:0]              period_in,
  input  logic [NUM_CH-1:0]             period_we,
  input  logic [NUM_CH-1:0]             tick_ack,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             overrun
);

  import tick_pkg::*;

  localparam int CH_MODES = 1 << MODE_W;

  // Each channel takes its own slice of the mode mask and sees only its own strobes.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CH_MODES-1:0] ch_mask;
    logic                ch_active;

    assign ch_mask   = mode_mask[c*CH_MODES +: CH_MODES];
    assign ch_active = ch_mask[mode];

    tick_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .active_i     (ch_active),
      .pulse_mode_i (pulse_mode[c]),
      .period_i     (period_in),
      .period_we_i  (period_we[c]),
      .ack_i        (tick_ack[c]),
      .tick_o       (tick[c]),
      .overrun_o    (overrun[c])
    );
  end

endmodule

// File: tb/tb_tick_generator_mc.sv
// tb/tb_tick_generator_mc.sv - directed self-checking bench for tick_generator_mc
module tb_tick_generator_mc;
  import tick_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  mode;
  logic [31:0] mode_mask;
  logic [3:0]  pulse_mode;
  logic [14:0] period_in;
  logic [3:0]  period_we;
  logic [3:0]  tick_ack;
  logic [3:0]  tick;
  logic [3:0]  overrun;

  int tests_run;
  int tests_failed;

  tick_generator_mc #(
    .NUM_CH(4), .CNT_W(15), .MODE_W(3), .DEFAULT_PERIOD(16385)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .mode_mask(mode_mask),
    .pulse_mode(pulse_mode), .period_in(period_in), .period_we(period_we),
    .tick_ack(tick_ack), .tick(tick), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Write strobe held for exactly one posedge; returns at the negedge after that edge.
  task automatic write_period(input int ch, input int p);
    period_in = 15'(p);
    period_we = 4'b0001 << ch;
    @(negedge clk);
    period_we = 4'b0000;
  endtask

  task automatic test_reset;
    mode_mask  = {MASK_GAMEPLAY, MASK_NONE, MASK_NONE, MASK_GAMEPLAY};
    pulse_mode = 4'b1000;
    mode       = MODE_IDLE;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (tick !== 4'b0000 || overrun !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_state: tick=%b overrun=%b expected 0000/0000", tick, overrun);
    end
    step(16384);
    tests_run++;
    if (tick[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL default_before_first: tick0=%b expected 0", tick[0]);
    end
    step(1);
    tests_run++;
    if (tick !== 4'b1001 || overrun !== 4'b0000) begin
      tests_failed++;
      $display("FAIL default_first_tick: tick=%b overrun=%b expected 1001/0000", tick, overrun);
    end
    step(16384);
    tests_run++;
    if (tick[0] !== 1'b1 || overrun[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL default_sticky_hold: tick0=%b ovr0=%b expected 1/0", tick[0], overrun[0]);
    end
    step(1);
    tests_run++;
    if (tick[0] !== 1'b1 || overrun[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL default_overrun: tick0=%b ovr0=%b expected 1/1", tick[0], overrun[0]);
    end
  endtask

  task automatic test_reset_mid;
    step(5);
    tests_run++;
    if (tick[0] !== 1'b1 || overrun[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_precondition: tick0=%b ovr0=%b expected 1/1", tick[0], overrun[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (tick !== 4'b0000 || overrun !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_reset_clear: tick=%b overrun=%b expected 0000/0000", tick, overrun);
    end
    step(16384);
    tests_run++;
    if (tick !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_reset_early: tick=%b expected 0000", tick);
    end
    step(1);
    tests_run++;
    if (tick !== 4'b1001) begin
      tests_failed++;
      $display("FAIL mid_reset_period: tick=%b expected 1001", tick);
    end
    mode_mask = '0;
    step(1);
  endtask

  task automatic test_pulse_timing;
    mode_mask[15:8] = MASK_GAMEPLAY;
    pulse_mode[1]   = 1'b1;
    mode            = MODE_IDLE;
    write_period(1, 5);
    for (int i = 1; i <= 12; i++) begin
      step(1);
      tests_run++;
      if (tick[1] !== ((i % 5) == 0)) begin
        tests_failed++;
        $display("FAIL pulse_p5 cycle %0d: tick1=%b expected %b", i, tick[1], ((i % 5) == 0));
      end
    end
  endtask

  task automatic test_mode_gating;
    mode_mask[23:16] = MASK_GAMEPLAY;
    pulse_mode[2]    = 1'b1;
    write_period(2, 10);
    step(6);
    mode = MODE_ATTRACT;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      tests_run++;
      if (tick[2] !== 1'b0) begin
        tests_failed++;
        $display("FAIL gated_inactive cycle %0d: tick2=%b expected 0", i, tick[2]);
      end
    end
    mode = MODE_IDLE;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      tests_run++;
      if (tick[2] !== (i == 10)) begin
        tests_failed++;
        $display("FAIL gated_reentry cycle %0d: tick2=%b expected %b", i, tick[2], (i == 10));
      end
    end
  endtask

  task automatic test_sticky_ack;
    mode_mask[7:0] = MASK_GAMEPLAY;
    pulse_mode[0]  = 1'b0;
    write_period(0, 4);
    step(4);
    tests_run++;
    if (tick[0] !== 1'b1 || overrun[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL sticky_first: tick0=%b ovr0=%b expected 1/0", tick[0], overrun[0]);
    end
    step(3);
    tick_ack[0] = 1'b1;
    step(1);
    tick_ack[0] = 1'b0;
    tests_run++;
    if (tick[0] !== 1'b1 || overrun[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_on_fire: tick0=%b ovr0=%b expected 1/0", tick[0], overrun[0]);
    end
    step(1);
    tick_ack[0] = 1'b1;
    step(1);
    tick_ack[0] = 1'b0;
    tests_run++;
    if (tick[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_non_fire: tick0=%b expected 0", tick[0]);
    end
    step(2);
    tests_run++;
    if (tick[0] !== 1'b1 || overrun[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL sticky_refire: tick0=%b ovr0=%b expected 1/0", tick[0], overrun[0]);
    end
    step(4);
    tests_run++;
    if (tick[0] !== 1'b1 || overrun[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sticky_overrun: tick0=%b ovr0=%b expected 1/1", tick[0], overrun[0]);
    end
    tick_ack[0] = 1'b1;
    step(1);
    tick_ack[0] = 1'b0;
    tests_run++;
    if (tick[0] !== 1'b0 || overrun[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_clears_overrun: tick0=%b ovr0=%b expected 0/0", tick[0], overrun[0]);
    end
  endtask

  task automatic test_boundaries;
    int highs;
    mode = MODE_IDLE;
    write_period(1, 0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick[1] === 1'b1) highs++;
    end
    tests_run++;
    if (highs !== 0) begin
      tests_failed++;
      $display("FAIL period_zero: %0d ticks seen, expected 0", highs);
    end
    write_period(1, 1);
    highs = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (tick[1] === 1'b1) highs++;
    end
    tests_run++;
    if (highs !== 5) begin
      tests_failed++;
      $display("FAIL period_one: %0d of 5 cycles high, expected 5", highs);
    end
    write_period(1, 20);
    step(7);
    write_period(1, 3);
    step(2);
    tests_run++;
    if (tick[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL shrink_early: tick1=%b expected 0", tick[1]);
    end
    step(1);
    tests_run++;
    if (tick[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL shrink_restart: tick1=%b expected 1", tick[1]);
    end
    step(2);
    write_period(1, 3);
    tests_run++;
    if (tick[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_on_fire: tick1=%b expected 0", tick[1]);
    end
    step(2);
    tests_run++;
    if (tick[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_on_fire_gap: tick1=%b expected 0", tick[1]);
    end
    step(1);
    tests_run++;
    if (tick[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_on_fire_next: tick1=%b expected 1", tick[1]);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    mode         = 3'b000;
    mode_mask    = '0;
    pulse_mode   = '0;
    period_in    = '0;
    period_we    = '0;
    tick_ack     = '0;
    test_reset();
    test_reset_mid();
    test_pulse_timing();
    test_mode_gating();
    test_sticky_ack();
    test_boundaries();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
